// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, LSB-first data capture.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_rx #(
  parameter int CLK_PER_BIT = 868,
  parameter int PACK_SIZE   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_bit,
  output logic                 rx_byte_valid,
  output logic [PACK_SIZE-1:0] rx_byte_data,
  output logic                 rx_active,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int IW = (PACK_SIZE > 1) ? $clog2(PACK_SIZE) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'((CLK_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PACK_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY = 3'd4
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [1:0]             sync_q, sync_d;
  logic [PACK_SIZE-1:0]   shift_q, shift_d;
  logic [PACK_SIZE-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   active_q, active_d;
  logic                   ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif
  logic                   rx_s;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d   = {sync_q[0], rx_bit};
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    active_d = active_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d    = par_q;
    perr_d   = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d  = S_START;
          active_d = 1'b1;
        end
      end

      // A start bit that is high again at its midpoint was only a glitch.
      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = S_DATA;
          end else begin
            state_d  = S_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif

      // Returning to IDLE at mid-stop-bit lets a back-to-back start edge be caught.
      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          active_d = 1'b0;
          if (rx_s) begin
            valid_d = 1'b1;
            data_d  = shift_q;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_q;
`endif
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sync_q   <= 2'b11;
      shift_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q    <= 1'b0;
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sync_q   <= sync_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign rx_byte_valid = valid_q;
  assign rx_byte_data  = data_q;
  assign rx_active     = active_q;
  assign rx_frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule
